// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: registered match flag when the last `len` accepted
// bits equal a programmable pattern, with overlap control and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned MAX_LEN     = 8,
    parameter logic [31:0] DEF_PATTERN = 32'b0000_0110,
    parameter int unsigned DEF_LEN     = 3,
    parameter bit          DEF_OVERLAP = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           x_valid,
    input  logic                           x,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           y,
    output logic [CNT_W-1:0]               match_count
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
    logic [MAX_LEN-1:0] pat_q, pat_d, mask;
    logic [LW-1:0]      fill_q, fill_d, fill_inc;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               y_q, y_d;
    logic               match;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign hist_shift = {hist_q[MAX_LEN-2:0], x};
    assign fill_inc   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LW'(1);

    // Fill guard keeps stale history from reset/config from ever matching.
    assign match = x_valid && !cfg_we && (fill_inc >= len_q) &&
                   (((hist_shift ^ pat_q) & mask) == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        y_d    = 1'b0;
        cnt_d  = cnt_clr ? '0 : cnt_q;

        // A clear coinciding with a match still records that match.
        if (match && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end

        if (cfg_we) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            if (cfg_len == '0) begin
                len_d = LW'(1);
            end else if (cfg_len > MAX_LEN_L) begin
                len_d = MAX_LEN_L;
            end else begin
                len_d = cfg_len;
            end
        end else if (x_valid) begin
            hist_d = hist_shift;
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            y_d    = match;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PATTERN[MAX_LEN-1:0];
            len_q  <= LW'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y           = y_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_seq_detect_param;

    typedef struct {
        bit         r;
        bit         v;
        bit         xb;
        bit         we;
        logic [7:0] p;
        logic [3:0] l;
        bit         o;
        bit         c;
        bit         ey;
        int         ec;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, x_valid, x, cfg_we, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       y, y2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model state
    bit         mq[$];
    logic [7:0] mpat;
    int         mlen;
    bit         movl;
    bit         my;
    int         mcnt, mcnt2;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y), .match_count(cnt)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y2), .match_count(cnt2)
    );

    function automatic vec_t mk(bit r, bit v, bit xb, bit we, logic [7:0] p, logic [3:0] l,
                                bit o, bit c, bit ey, int ec);
        vec_t t;
        t.r = r; t.v = v; t.xb = xb; t.we = we; t.p = p; t.l = l;
        t.o = o; t.c = c; t.ey = ey; t.ec = ec;
        return t;
    endfunction

    function automatic vec_t bitrow(bit xb, bit ey, int ec);
        return mk(0, 1, xb, 0, 8'h00, 4'd0, 0, 0, ey, ec);
    endfunction

    function automatic vec_t cfgrow(logic [7:0] p, logic [3:0] l, bit o, int ec);
        return mk(0, 0, 0, 1, p, l, o, 0, 0, ec);
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    endfunction

    function automatic bit tail_match();
        if (mq.size() < mlen) return 1'b0;
        for (int i = 0; i < mlen; i++) begin
            if (mq[mq.size() - 1 - i] != mpat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(vec_t t);
        my = 1'b0;
        if (t.r) begin
            mq.delete();
            mpat = 8'b0000_0110; mlen = 3; movl = 1'b1;
            mcnt = 0; mcnt2 = 0;
        end else begin
            if (t.c) begin
                mcnt = 0; mcnt2 = 0;
            end
            if (t.we) begin
                mpat = t.p;
                mlen = (t.l == 0) ? 1 : (t.l > 8) ? 8 : int'(t.l);
                movl = t.o;
                mq.delete();
            end else if (t.v) begin
                mq.push_back(t.xb);
                if (mq.size() > 8) void'(mq.pop_front());
                if (tail_match()) begin
                    my = 1'b1;
                    if (mcnt < 255) mcnt++;
                    if (mcnt2 < 3) mcnt2++;
                    if (!movl) mq.delete();
                end
            end
        end
    endtask

    task automatic apply(vec_t t);
        reset = t.r; x_valid = t.v; x = t.xb; cfg_we = t.we;
        cfg_pattern = t.p; cfg_len = t.l; cfg_overlap = t.o; cnt_clr = t.c;
        @(posedge clk);
        #1;
        model_update(t);
        chk("model_y", int'(y), int'(my));
        chk("model_y2", int'(y2), int'(my));
        chk("model_cnt", int'(cnt), mcnt);
        chk("model_cnt2", int'(cnt2), mcnt2);
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; x_valid = 1'b0; x = 1'b0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

        // Default config 110: stream 1,1,0,1,1,0
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0));
        tbl.push_back(bitrow(1, 0, 0)); tbl.push_back(bitrow(1, 0, 0));
        tbl.push_back(bitrow(0, 1, 1)); tbl.push_back(bitrow(1, 0, 1));
        tbl.push_back(bitrow(1, 0, 1)); tbl.push_back(bitrow(0, 1, 2));
        // 101 overlapping, then non-overlapping
        tbl.push_back(cfgrow(8'b101, 4'd3, 1, 2));
        tbl.push_back(bitrow(1, 0, 2)); tbl.push_back(bitrow(0, 0, 2));
        tbl.push_back(bitrow(1, 1, 3)); tbl.push_back(bitrow(0, 0, 3));
        tbl.push_back(bitrow(1, 1, 4));
        tbl.push_back(cfgrow(8'b101, 4'd3, 0, 4));
        tbl.push_back(bitrow(1, 0, 4)); tbl.push_back(bitrow(0, 0, 4));
        tbl.push_back(bitrow(1, 1, 5)); tbl.push_back(bitrow(0, 0, 5));
        tbl.push_back(bitrow(1, 0, 5));
        // 000 needs three fresh bits
        tbl.push_back(cfgrow(8'b000, 4'd3, 1, 5));
        tbl.push_back(bitrow(0, 0, 5)); tbl.push_back(bitrow(0, 0, 5));
        tbl.push_back(bitrow(0, 1, 6));
        // Config write clears history mid-pattern
        tbl.push_back(cfgrow(8'b110, 4'd3, 1, 6));
        tbl.push_back(bitrow(1, 0, 6)); tbl.push_back(bitrow(1, 0, 6));
        tbl.push_back(cfgrow(8'b110, 4'd3, 1, 6));
        tbl.push_back(bitrow(0, 0, 6));
        // Clear on the same edge as a match
        tbl.push_back(bitrow(1, 0, 6)); tbl.push_back(bitrow(1, 0, 6));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 4'd0, 0, 1, 1, 1));
        // Reset mid-pattern
        tbl.push_back(bitrow(1, 0, 1)); tbl.push_back(bitrow(1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0));
        tbl.push_back(bitrow(0, 0, 0));
        // cfg_len=0 acts as 1; period-1 pattern holds y high
        tbl.push_back(cfgrow(8'b1, 4'd0, 1, 0));
        tbl.push_back(bitrow(1, 1, 1)); tbl.push_back(bitrow(1, 1, 2));
        tbl.push_back(bitrow(0, 0, 2));
        // cfg_len=15 clamps to 8
        tbl.push_back(cfgrow(8'b1010_0110, 4'd15, 1, 2));
        tbl.push_back(bitrow(1, 0, 2)); tbl.push_back(bitrow(0, 0, 2));
        tbl.push_back(bitrow(1, 0, 2)); tbl.push_back(bitrow(0, 0, 2));
        tbl.push_back(bitrow(0, 0, 2)); tbl.push_back(bitrow(1, 0, 2));
        tbl.push_back(bitrow(1, 0, 2)); tbl.push_back(bitrow(0, 1, 3));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d_y", i), int'(y), int'(tbl[i].ey));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].ec);
        end

        // Valid gaps: 1,1,0 separated by 2..5 idle cycles
        apply(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0));
        for (int b = 0; b < 3; b++) begin
            apply(bitrow((b < 2) ? 1'b1 : 1'b0, 0, 0));
            chk($sformatf("gap_bit%0d_y", b), int'(y), (b == 2) ? 1 : 0);
            for (int g = 0; g < int'($urandom_range(2, 5)); g++) begin
                apply(idle());
                chk("gap_idle_y", int'(y), 0);
            end
        end
        chk("gap_cnt", int'(cnt), 1);

        // Counter saturation with a 2-bit counter
        apply(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0));
        apply(cfgrow(8'b1, 4'd1, 1, 0));
        for (int k = 0; k < 5; k++) apply(bitrow(1, 1, 0));
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_cnt8", int'(cnt), 5);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            vec_t t;
            t.r  = ($urandom_range(0, 199) == 0);
            t.we = ($urandom_range(0, 49) == 0);
            t.v  = ($urandom_range(0, 3) != 0);
            t.xb = $urandom_range(0, 1);
            t.p  = 8'($urandom);
            t.l  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
            t.o  = $urandom_range(0, 1);
            t.c  = ($urandom_range(0, 39) == 0);
            t.ey = 0;
            t.ec = 0;
            apply(t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
